// File: rtl/cache_write_merge_buffer.sv
// Write-merge buffer between store pipeline and cache data array.
// Accepted store hits are merged into a line-wide entry. Consecutive stores
// to the same {set, way} coalesce into the youngest entry. Entries drain
// in FIFO order through the wb_* handshake.
module cache_write_merge_buffer #(
  parameter int LINE_BITS = 256,
  parameter int WORD_BITS = 32,
  parameter int WAYS      = 2,
  parameter int DEPTH     = 4,
  parameter int IDX_BITS  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [WAYS-1:0]                   req_hit,
  input  logic [WAYS*LINE_BITS-1:0]         req_way_data,
  input  logic [IDX_BITS-1:0]               req_index,
  input  logic [$clog2(LINE_BITS/8)-1:0]    req_offset,
  input  logic [WORD_BITS-1:0]              req_wdata,
  input  logic [WORD_BITS/8-1:0]            req_byte_en,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [IDX_BITS-1:0]               wb_index,
  output logic [WAYS-1:0]                   wb_way,
  output logic [LINE_BITS-1:0]              wb_data,
  output logic [LINE_BITS/8-1:0]            wb_mask,
  output logic                              miss,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int OFF_BITS = $clog2(LINE_BITS/8);
  localparam int WB       = WORD_BITS/8;
  localparam int LB       = LINE_BITS/8;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [OFF_BITS-1:0] ALIGN_MASK = ~OFF_BITS'(WB-1);

  logic [IDX_BITS-1:0]  r_idx  [DEPTH];
  logic [WAYS-1:0]      r_way  [DEPTH];
  logic [LINE_BITS-1:0] r_data [DEPTH];
  logic [LB-1:0]        r_mask [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_miss;

  logic                 w_accept;
  logic                 w_pop;
  logic                 w_store;
  logic                 w_match;
  logic                 w_coal;
  logic                 w_alloc;
  logic [PTR_W-1:0]     w_last;
  logic [WAYS-1:0]      w_sel_oh;
  logic [LINE_BITS-1:0] w_base;
  logic [OFF_BITS-1:0]  w_eff;
  logic [LINE_BITS-1:0] w_new_data;
  logic [LB-1:0]        w_new_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH-1) : p - 1'b1;
  endfunction

  assign req_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = (r_count != '0) && wb_ready;
  assign w_store   = w_accept && (req_hit != '0) && (req_byte_en != '0);
  assign w_last    = ptr_dec(r_tail);
  assign w_eff     = req_offset & ALIGN_MASK;

  // Lowest-numbered hitting way wins; its line becomes the merge base.
  always_comb begin
    w_sel_oh = '0;
    w_base   = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (req_hit[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_base      = req_way_data[i*LINE_BITS +: LINE_BITS];
      end
    end
  end

  // Coalesce only into the youngest entry, and never into one leaving this cycle.
  assign w_match = (r_count != '0) && (r_idx[w_last] == req_index) &&
                   (r_way[w_last] == w_sel_oh) &&
                   !(w_pop && (r_count == CNT_W'(1)));
  assign w_coal  = w_store && w_match;
  assign w_alloc = w_store && !w_match;

  // Overlay the enabled store bytes onto either the tail entry or the way line.
  always_comb begin
    logic [OFF_BITS-1:0] pos;
    pos        = '0;
    w_new_data = w_match ? r_data[w_last] : w_base;
    w_new_mask = w_match ? r_mask[w_last] : '0;
    for (int i = 0; i < WB; i++) begin
      pos = w_eff + OFF_BITS'(i);
      if (req_byte_en[i]) begin
        w_new_data[{pos, 3'b000} +: 8] = req_wdata[i*8 +: 8];
        w_new_mask[pos]                = 1'b1;
      end
    end
  end

  // Entry storage, FIFO pointers, occupancy and the miss pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i]  <= '0;
        r_way[i]  <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_miss  <= 1'b0;
    end else begin
      if (w_coal) begin
        r_data[w_last] <= w_new_data;
        r_mask[w_last] <= w_new_mask;
      end
      if (w_alloc) begin
        r_idx[r_tail]  <= req_index;
        r_way[r_tail]  <= w_sel_oh;
        r_data[r_tail] <= w_new_data;
        r_mask[r_tail] <= w_new_mask;
        r_tail         <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
      r_miss  <= w_accept && (req_hit == '0);
    end
  end

  assign wb_valid = (r_count != '0);
  assign wb_index = wb_valid ? r_idx[r_head]  : '0;
  assign wb_way   = wb_valid ? r_way[r_head]  : '0;
  assign wb_data  = wb_valid ? r_data[r_head] : '0;
  assign wb_mask  = wb_valid ? r_mask[r_head] : '0;
  assign miss     = r_miss;
  assign count    = r_count;

endmodule

// File: tb/tb_cache_write_merge_buffer.sv
// Bench for cache_write_merge_buffer: scoreboard of expected buffer entries
// updated as stores are driven, compared against the head on every cycle.
module tb_cache_write_merge_buffer;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_hit;
  logic [511:0] req_way_data;
  logic [2:0]   req_index;
  logic [4:0]   req_offset;
  logic [31:0]  req_wdata;
  logic [3:0]   req_byte_en;
  logic         wb_valid;
  logic         wb_ready;
  logic [2:0]   wb_index;
  logic [1:0]   wb_way;
  logic [255:0] wb_data;
  logic [31:0]  wb_mask;
  logic         miss;
  logic [2:0]   count;

  typedef struct {
    logic [2:0]   idx;
    logic [1:0]   way;
    logic [255:0] data;
    logic [31:0]  mask;
  } ent_t;

  ent_t sb[$];
  logic exp_miss;
  int   n_checks;
  int   n_errors;

  cache_write_merge_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_hit      (req_hit),
    .req_way_data (req_way_data),
    .req_index    (req_index),
    .req_offset   (req_offset),
    .req_wdata    (req_wdata),
    .req_byte_en  (req_byte_en),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_index     (wb_index),
    .wb_way       (wb_way),
    .wb_data      (wb_data),
    .wb_mask      (wb_mask),
    .miss         (miss),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] hit, input logic [2:0] idx,
                       input logic [4:0] off, input logic [31:0] wd, input logic [3:0] be);
    req_valid   = v;
    req_hit     = hit;
    req_index   = idx;
    req_offset  = off;
    req_wdata   = wd;
    req_byte_en = be;
  endtask

  // Check outputs against the scoreboard, advance the model across one edge.
  task automatic step();
    ent_t         e;
    logic [1:0]   oh;
    logic [255:0] base;
    logic [4:0]   eff;
    logic [4:0]   p;
    logic         pop, acc, store, match;
    int           n;
    n = sb.size();
    chk("count",     256'(count),     256'(n));
    chk("req_ready", 256'(req_ready), 256'(n < 4));
    chk("wb_valid",  256'(wb_valid),  256'(n != 0));
    chk("miss",      256'(miss),      256'(exp_miss));
    if (n != 0) begin
      chk("head_index", 256'(wb_index), 256'(sb[0].idx));
      chk("head_way",   256'(wb_way),   256'(sb[0].way));
      chk("head_data",  wb_data,        sb[0].data);
      chk("head_mask",  256'(wb_mask),  256'(sb[0].mask));
    end else begin
      chk("empty_out", {wb_data, 29'(0), wb_index} ^ 256'(wb_mask) ^ 256'(wb_way), 256'(0));
    end
    pop   = (n != 0) && wb_ready;
    acc   = req_valid && (n < 4);
    store = acc && (req_hit != 2'b00) && (req_byte_en != 4'h0);
    match = 1'b0;
    if (store) begin
      oh    = req_hit[0] ? 2'b01 : 2'b10;
      base  = req_hit[0] ? req_way_data[255:0] : req_way_data[511:256];
      eff   = req_offset & 5'h1C;
      match = (n > 0) && (sb[n-1].idx == req_index) && (sb[n-1].way == oh) && !(pop && n == 1);
      if (match) e = sb[n-1];
      else begin
        e.idx  = req_index;
        e.way  = oh;
        e.data = base;
        e.mask = '0;
      end
      for (int i = 0; i < 4; i++) begin
        p = eff + 5'(i);
        if (req_byte_en[i]) begin
          e.data[{p, 3'b000} +: 8] = req_wdata[i*8 +: 8];
          e.mask[p] = 1'b1;
        end
      end
      if (match) sb[n-1] = e;
    end
    if (pop) void'(sb.pop_front());
    if (store && !match) sb.push_back(e);
    exp_miss = acc && (req_hit == 2'b00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_miss = 1'b0;
    rst = 1'b1;
    wb_ready = 1'b0;
    req_way_data = '0;
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("rst_count",     256'(count),     256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_wb_valid",  256'(wb_valid),  256'(0));
    chk("rst_miss",      256'(miss),      256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Word store into empty buffer, then coalesce a byte into it.
    drive(1'b1, 2'b01, 3'd3, 5'd4, 32'hAABBCCDD, 4'hF);
    step();
    chk("w_mask",  256'(wb_mask),        256'(32'h000000F0));
    chk("w_data",  256'(wb_data[63:32]), 256'(32'hAABBCCDD));
    chk("w_way",   256'(wb_way),         256'(2'b01));
    chk("w_index", 256'(wb_index),       256'(3));
    drive(1'b1, 2'b01, 3'd3, 5'd8, 32'h000000EE, 4'b0001);
    step();
    chk("c_count", 256'(count),          256'(1));
    chk("c_byte",  256'(wb_data[71:64]), 256'(8'hEE));
    chk("c_mask",  256'(wb_mask),        256'(32'h000001F0));
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Miss pulse, then a hit with no enabled bytes.
    drive(1'b1, 2'b00, 3'd1, 5'd0, 32'h12345678, 4'hF);
    step();
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    chk("miss_pulse", 256'(miss), 256'(1));
    step();
    drive(1'b1, 2'b10, 3'd2, 5'd0, 32'h12345678, 4'h0);
    step();
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    step();

    // Way selection with both ways hitting and with way 1 alone.
    req_way_data = {{8{32'hA5A5_0001}}, {8{32'h5A5A_0000}}};
    drive(1'b1, 2'b11, 3'd6, 5'd13, 32'hDEADBEEF, 4'b0110);
    step();
    drive(1'b1, 2'b10, 3'd6, 5'd31, 32'hCAFEF00D, 4'b1001);
    step();
    chk("ws_count", 256'(count), 256'(2));

    // Fill to capacity, attempt a store while full, pop one.
    drive(1'b1, 2'b01, 3'd0, 5'd0, 32'h01010101, 4'hF);
    step();
    drive(1'b1, 2'b01, 3'd1, 5'd0, 32'h02020202, 4'hF);
    step();
    chk("full_count", 256'(count),     256'(4));
    chk("full_ready", 256'(req_ready), 256'(0));
    drive(1'b1, 2'b01, 3'd2, 5'd0, 32'h03030303, 4'hF);
    step();
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("pop_count", 256'(count),     256'(3));
    chk("pop_ready", 256'(req_ready), 256'(1));
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Head-pop race with a store to the same set and way.
    req_way_data = '0;
    wb_ready = 1'b0;
    drive(1'b1, 2'b01, 3'd5, 5'd0, 32'h99999999, 4'hF);
    step();
    wb_ready = 1'b1;
    drive(1'b1, 2'b01, 3'd5, 5'd4, 32'h00001122, 4'b0011);
    step();
    chk("race_count", 256'(count),          256'(1));
    chk("race_mask",  256'(wb_mask),        256'(32'h00000030));
    chk("race_data",  256'(wb_data[47:32]), 256'(16'h1122));
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    step();

    // Random traffic to exercise coalescing, wrap-around and backpressure.
    for (int c = 0; c < 400; c++) begin
      req_way_data = {16{$urandom}};
      for (int k = 0; k < 16; k++) req_way_data[k*32 +: 32] = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom_range(0, 1)),
            5'($urandom), $urandom, 4'($urandom));
      wb_ready = 1'($urandom_range(0, 2) == 0);
      step();
    end

    // Reset in the middle of operation with three entries buffered.
    wb_ready = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    for (int i = 0; i < 5; i++) step();
    wb_ready = 1'b0;
    req_way_data = {16{32'h77777777}};
    drive(1'b1, 2'b01, 3'd0, 5'd0, 32'h11111111, 4'hF);
    step();
    drive(1'b1, 2'b01, 3'd1, 5'd0, 32'h22222222, 4'hF);
    step();
    drive(1'b1, 2'b10, 3'd2, 5'd0, 32'h33333333, 4'hF);
    step();
    chk("pre_rst_count", 256'(count), 256'(3));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count",    256'(count),     256'(0));
    chk("mid_rst_wb_valid", 256'(wb_valid),  256'(0));
    chk("mid_rst_wb_data",  wb_data,         256'(0));
    chk("mid_rst_ready",    256'(req_ready), 256'(1));
    @(posedge clk);
    #1;
    chk("rst_no_accept", 256'(count), 256'(0));
    rst = 1'b0;
    sb.delete();
    exp_miss = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 4'h0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_write_merge_buffer.md
CACHE_WRITE_MERGE_BUFFER -- requirements
Module: cache_write_merge_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 - LINE_BITS, 256, cache line width.
 - WORD_BITS, 32, store word width.
 - WAYS, 2, associativity.
 - DEPTH, 4, buffer entries.
 - IDX_BITS, 3, set index width.
 - OFF_BITS = log2(LINE_BITS/8); WB = WORD_BITS/8; LB = LINE_BITS/8.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset. Ports (name, direction, width, meaning):
 - clk, in, 1, clock.
 - rst, in, 1, asynchronous active-high reset.
 - req_valid, in, 1, store request valid.
 - req_ready, out, 1, request accepted when high with req_valid.
 - req_hit, in, WAYS, per-way hit.
 - req_way_data, in, WAYS*LINE_BITS, line data of each way, way w at [w*LINE_BITS +: LINE_BITS].
 - req_index, in, IDX_BITS, set index.
 - req_offset, in, OFF_BITS, byte offset in line.
 - req_wdata, in, WORD_BITS, store data.
 - req_byte_en, in, WB, byte enables.
 - wb_valid, out, 1, head entry valid.
 - wb_ready, in, 1, data array accepts head.
 - wb_index, out, IDX_BITS, head set index.
 - wb_way, out, WAYS, head way, one-hot.
 - wb_data, out, LINE_BITS, head merged line.
 - wb_mask, out, LB, head dirty-byte mask.
 - miss, out, 1, one-cycle pulse for an accepted store that hit no way.
 - count, out, log2(DEPTH)+1, occupied entries.

Function
REQ-003 req_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state.
REQ-004 Acceptance SHALL occur on a rising edge with req_valid && req_ready.
REQ-005 Selected way SHALL be the lowest-numbered set bit of req_hit.
REQ-006 The effective offset SHALL be req_offset with its low log2(WB) bits forced to 0.
REQ-007 Merge: for each i < WB with req_byte_en[i]=1, line byte (eff_offset+i) SHALL take req_wdata[8i+7:8i] and the matching mask bit SHALL be set. All other bytes SHALL keep the base line.
REQ-008 Coalesce: when count>0 and the tail entry matches {req_index, selected way} and the tail is not being popped this cycle, the accepted store SHALL merge into the tail entry's data and mask, and count SHALL not increase.
REQ-009 Allocate: otherwise the store SHALL write a new tail entry with base = selected way data, mask = enabled bytes only.
REQ-010 Accepted store with req_hit == 0 SHALL create or modify no entry, and miss SHALL be 1 in the next cycle only.
REQ-011 Accepted hit with req_byte_en == 0 SHALL create or modify no entry, and miss SHALL stay 0.
REQ-012 wb_valid SHALL equal (count != 0). wb_index, wb_way, wb_data and wb_mask SHALL show the head entry, and SHALL be all-zero when empty.
REQ-013 wb_valid && wb_ready SHALL pop the head on the rising edge.
REQ-014 Simultaneous allocate and pop SHALL leave count unchanged. Coalesce with a pop of a different entry SHALL decrement count.
REQ-015 Head and tail pointers SHALL wrap modulo DEPTH. The FIFO order of entries SHALL be preserved.
REQ-016 An accepted store SHALL be visible on wb_* no earlier than the next cycle (1-cycle latency into an empty buffer).
REQ-017 Outputs SHALL hold while wb_valid && !wb_ready (no change to head contents except by coalesce when head == tail and no pop).

Reset
REQ-018 rst=1 SHALL immediately clear count, pointers, all entries, wb_valid, wb_index, wb_way, wb_data, wb_mask and miss to 0, and SHALL drive req_ready=1.
REQ-019 Reset mid-operation SHALL discard all buffered stores, and a request presented during reset SHALL not be accepted.

Verification
REQ-020 Word store: hit=2'b01, way0 data=0, index=3, offset=5'd4, wdata=32'hAABBCCDD, byte_en=4'hF -> next cycle wb_valid=1, wb_way=01, wb_index=3, wb_data[63:32]=AABBCCDD, wb_mask=32'h000000F0.
REQ-021 Coalesce: as REQ-020 with wb_ready=0, then store offset=8, byte_en=4'b0001, wdata=...EE, same index and way -> count=1, wb_data[71:64]=8'hEE, wb_mask=32'h000001F0.
REQ-022 Miss: hit=2'b00 accepted -> count unchanged, miss=1 for exactly one cycle.
REQ-023 Full: four stores to distinct indices with wb_ready=0 -> count=4, req_ready=0. Then raise wb_ready for one cycle -> oldest entry popped, count=3, req_ready=1.
REQ-024 Head-pop race: count=1, wb_ready=1, matching store accepted the same cycle -> head popped and new entry allocated, count=1, wb_mask holds only the new bytes.
REQ-025 Reset: assert rst with count=3 -> count=0, wb_valid=0, wb_data=0 before the next clock edge.
